// File: rtl/screen_pixel_arbiter.sv
// Pixel fetch arbiter: routes each screen-driver pixel request to the overlay or
// background source based on a per-frame shadowed window, with ack timeout fallback.
module screen_pixel_arbiter #(
    parameter int unsigned SCREEN_WIDTH  = 320,
    parameter int unsigned SCREEN_HEIGHT = 240,
    parameter int unsigned TIMEOUT       = 64,
    parameter logic [15:0] DEFAULT_COLOR = 16'h0000
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        frame_start_i,
    input  logic        pix_update_i,
    input  logic [15:0] pix_x_i,
    input  logic [15:0] pix_y_i,
    output logic [15:0] pix_data_o,
    output logic        pix_valid_o,
    input  logic        cfg_win_en_i,
    input  logic [15:0] cfg_win_x_i,
    input  logic [15:0] cfg_win_y_i,
    input  logic [15:0] cfg_win_w_i,
    input  logic [15:0] cfg_win_h_i,
    output logic        bg_req_o,
    input  logic        bg_ack_i,
    input  logic [15:0] bg_data_i,
    output logic        ov_req_o,
    input  logic        ov_ack_i,
    input  logic [15:0] ov_data_i,
    output logic [15:0] src_x_o,
    output logic [15:0] src_y_o,
    output logic        busy_o,
    output logic        overrun_o,
    output logic [15:0] miss_cnt_o
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_REQ  = 1'b1;

    if (SCREEN_WIDTH > 65536 || SCREEN_HEIGHT > 65536 || TIMEOUT < 1) begin : g_param_check
        $error("screen_pixel_arbiter: coordinates must fit 16 bits and TIMEOUT must be >= 1");
    end

    logic [0:0]       state_q, state_d;
    logic             sel_ov_q, sel_ov_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      src_x_q, src_x_d;
    logic [15:0]      src_y_q, src_y_d;
    logic [15:0]      data_q, data_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;
    logic [15:0]      miss_q, miss_d;

    logic             sh_en_q;
    logic [15:0]      sh_x_q, sh_y_q, sh_w_q, sh_h_q;

    logic             eff_en;
    logic [15:0]      eff_x, eff_y, eff_w, eff_h;
    logic [16:0]      x_end, y_end;
    logic             hit;
    logic             ack;

    // A frame_start coinciding with an update must see the new window, so forward cfg.
    always_comb begin
        eff_en = frame_start_i ? cfg_win_en_i : sh_en_q;
        eff_x  = frame_start_i ? cfg_win_x_i  : sh_x_q;
        eff_y  = frame_start_i ? cfg_win_y_i  : sh_y_q;
        eff_w  = frame_start_i ? cfg_win_w_i  : sh_w_q;
        eff_h  = frame_start_i ? cfg_win_h_i  : sh_h_q;
        x_end  = {1'b0, eff_x} + {1'b0, eff_w};
        y_end  = {1'b0, eff_y} + {1'b0, eff_h};
        hit    = eff_en
                 && (pix_x_i >= eff_x) && ({1'b0, pix_x_i} < x_end)
                 && (pix_y_i >= eff_y) && ({1'b0, pix_y_i} < y_end);
    end

    assign ack = sel_ov_q ? ov_ack_i : bg_ack_i;

    always_comb begin
        state_d   = state_q;
        sel_ov_d  = sel_ov_q;
        cnt_d     = cnt_q;
        src_x_d   = src_x_q;
        src_y_d   = src_y_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        miss_d    = miss_q;
        overrun_d = overrun_q;

        if (frame_start_i) begin
            overrun_d = 1'b0;
        end
        if (pix_update_i && state_q == ST_REQ) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (pix_update_i) begin
                    state_d  = ST_REQ;
                    sel_ov_d = hit;
                    cnt_d    = '0;
                    src_x_d  = hit ? (pix_x_i - eff_x) : pix_x_i;
                    src_y_d  = hit ? (pix_y_i - eff_y) : pix_y_i;
                end
            end
            default: begin
                // Ack takes priority over a timeout expiring in the same cycle.
                if (ack) begin
                    state_d = ST_IDLE;
                    data_d  = sel_ov_q ? ov_data_i : bg_data_i;
                    valid_d = 1'b1;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d = ST_IDLE;
                    data_d  = DEFAULT_COLOR;
                    valid_d = 1'b1;
                    if (miss_q != 16'hFFFF) begin
                        miss_d = miss_q + 16'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q   <= ST_IDLE;
            sel_ov_q  <= 1'b0;
            cnt_q     <= '0;
            src_x_q   <= '0;
            src_y_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            miss_q    <= '0;
            sh_en_q   <= 1'b0;
            sh_x_q    <= '0;
            sh_y_q    <= '0;
            sh_w_q    <= '0;
            sh_h_q    <= '0;
        end else begin
            state_q   <= state_d;
            sel_ov_q  <= sel_ov_d;
            cnt_q     <= cnt_d;
            src_x_q   <= src_x_d;
            src_y_q   <= src_y_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            miss_q    <= miss_d;
            if (frame_start_i) begin
                sh_en_q <= cfg_win_en_i;
                sh_x_q  <= cfg_win_x_i;
                sh_y_q  <= cfg_win_y_i;
                sh_w_q  <= cfg_win_w_i;
                sh_h_q  <= cfg_win_h_i;
            end
        end
    end

    assign busy_o      = (state_q == ST_REQ);
    assign ov_req_o    = (state_q == ST_REQ) &&  sel_ov_q;
    assign bg_req_o    = (state_q == ST_REQ) && !sel_ov_q;
    assign src_x_o     = src_x_q;
    assign src_y_o     = src_y_q;
    assign pix_data_o  = data_q;
    assign pix_valid_o = valid_q;
    assign overrun_o   = overrun_q;
    assign miss_cnt_o  = miss_q;

endmodule

// File: doc/screen_pixel_arbiter.md
SCREEN_PIXEL_ARBITER -- requirements
Module: screen_pixel_arbiter

Interface
REQ-001 Parameter SCREEN_WIDTH, default 320, horizontal pixel count (informational bound for coordinates).
REQ-002 Parameter SCREEN_HEIGHT, default 240, vertical pixel count.
REQ-003 Parameter TIMEOUT, default 64, max cycles req held without ack.
REQ-004 Parameter DEFAULT_COLOR, default 16'h0000, RGB565 value on timeout.
REQ-005 sys_clk  in  1  sole clock, all logic on rising edge.
REQ-006 sys_rst  in  1  synchronous, active-high reset.
REQ-007 frame_start_i  in  1  one-cycle pulse at start of each screen frame.
REQ-008 pix_update_i  in  1  one-cycle pixel fetch request from screen driver.
REQ-009 pix_x_i / pix_y_i  in  16 each  absolute pixel coordinate, valid with pix_update_i.
REQ-010 pix_data_o  out  16  RGB565 pixel returned to screen driver.
REQ-011 pix_valid_o  out  1  one-cycle pulse, pix_data_o newly updated.
REQ-012 cfg_win_en_i  in  1; cfg_win_x_i, cfg_win_y_i, cfg_win_w_i, cfg_win_h_i  in  16 each  overlay window config.
REQ-013 bg_req_o  out  1; bg_ack_i  in  1; bg_data_i  in  16  background source handshake.
REQ-014 ov_req_o  out  1; ov_ack_i  in  1; ov_data_i  in  16  overlay source handshake.
REQ-015 src_x_o / src_y_o  out  16 each  fetch coordinate: absolute for bg, window-relative for overlay.
REQ-016 busy_o  out  1  high in any state other than IDLE.
REQ-017 overrun_o  out  1  sticky: pix_update_i arrived while busy.
REQ-018 miss_cnt_o  out  16  count of timed-out fetches, saturating.

Function
REQ-019 FSM states IDLE, REQ; IDLE->REQ on pix_update_i; REQ->IDLE on selected ack or timeout.
REQ-020 Config shadow registers load from cfg_* on frame_start_i; otherwise hold.
REQ-021 Window hit decision in IDLE on pix_update_i: shadow en=1 and wx<=x<wx+ww and wy<=y<wy+wh, sums in 17-bit arithmetic (no wrap).
REQ-022 When frame_start_i and pix_update_i coincide, hit decision uses cfg_* inputs directly (forwarded), not old shadow.
REQ-023 ww=0 or wh=0 never hits; window extending past screen edges clipped implicitly by coordinate compare.
REQ-024 Hit -> ov_req_o, src_x_o=x-wx, src_y_o=y-wy; miss -> bg_req_o, src_x_o=x, src_y_o=y; src_* registered at request.
REQ-025 Latency: pix_update_i at cycle T -> selected req high at T+1; exactly one req high at any time.
REQ-026 Req held high until selected ack sampled high; ack at cycle A -> req low, pix_data_o=data, pix_valid_o=1 at A+1.
REQ-027 Ack on non-selected source, or any ack while no req high, ignored.
REQ-028 Timeout counter cleared on entry to REQ; after TIMEOUT cycles in REQ with no ack: req low, pix_data_o=DEFAULT_COLOR, pix_valid_o pulse, miss_cnt_o+1 (hold at 16'hFFFF), return IDLE.
REQ-029 Ack in the same cycle timeout expires: ack wins, no miss counted.
REQ-030 pix_update_i while busy: dropped, overrun_o set; overrun_o cleared by frame_start_i (set wins if simultaneous).
REQ-031 frame_start_i during REQ does not abort the transaction; new shadow affects next decision only.
REQ-032 pix_data_o holds last value between pix_valid_o pulses.

Reset
REQ-033 sys_rst high at clock edge: state IDLE, all req low, pix_data_o=0, pix_valid_o=0, busy_o=0, overrun_o=0, miss_cnt_o=0, src_*=0, shadow en=0 and geometry 0, timeout counter 0.
REQ-034 Reset mid-REQ drops req on next edge; a later ack is ignored.

Verification
REQ-035 Frame_start with window (10,20,32,16,en=1); update at (10,20) -> ov_req_o at T+1, src=(0,0); ov ack with 16'hF800 -> pix_data_o=16'hF800, pix_valid_o one cycle.
REQ-036 Same window; updates at (42,20) and (9,35) -> bg_req_o, src=(42,20)/(9,35); (41,35) -> overlay src=(31,15).
REQ-037 bg source never acks -> req drops after 64 cycles, pix_data_o=16'h0000, miss_cnt_o=1; ack at exactly cycle 64 -> data taken, miss_cnt_o unchanged.
REQ-038 Second pix_update_i while in REQ -> no new req, overrun_o=1; next frame_start_i -> overrun_o=0.
REQ-039 frame_start_i and pix_update_i at (0,0) same cycle with cfg window (0,0,1,1,en=1) -> overlay selected; cfg en=0 with w=0 -> background.
REQ-040 Assert sys_rst during REQ -> all outputs reset values next edge; late ack produces no pix_valid_o.
